// File: rtl/pkt_sf_fifo.sv
// rtl/pkt_sf_fifo.sv - store-and-forward packet FIFO; PKT_SF_FIFO_DROP_STATS_EN enables the drop counter
module pkt_sf_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int MOD_W  = $clog2(DATA_W / 8)
) (
    input  logic                     clk_156m25,
    input  logic                     reset_156m25_n,
    input  logic                     wr_en,
    input  logic                     wr_sop,
    input  logic                     wr_eop,
    input  logic [MOD_W-1:0]         wr_mod,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_err,
    output logic                     wr_full,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic                     rd_sop,
    output logic                     rd_eop,
    output logic [MOD_W-1:0]         rd_mod,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int MW = DATA_W + MOD_W + 2;
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DISCARD} wr_state_t;

    wr_state_t      state, state_nxt;
    logic [AW:0]    wp, cwp, rp, cwp_q;
    logic [AW:0]    wp_nxt, cwp_nxt;
    logic [AW-1:0]  mem_addr;
    logic           mem_we, commit, drop;
    logic [MW-1:0]  mem [DEPTH];
    logic [MW-1:0]  head_word;
    logic           rd_pop, load;

    assign wr_full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head_word = mem[rp[AW-1:0]];
    assign rd_pop    = rd_en && rd_valid;
    // committed pointer is seen one cycle late so commit-to-valid takes two edges
    assign load      = (cwp_q != rp) && (!rd_valid || rd_pop);

    // write FSM state register
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) state <= S_IDLE;
        else                 state <= state_nxt;
    end

    // write FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wr_en && wr_sop) begin
                    if (wr_eop)       state_nxt = S_IDLE;
                    else if (wr_full) state_nxt = S_DISCARD;
                    else              state_nxt = S_IN_PKT;
                end
            end
            S_IN_PKT: begin
                if (wr_en) begin
                    if (wr_eop)                  state_nxt = S_IDLE;
                    else if (!wr_sop && wr_full) state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (wr_en && wr_eop) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // write FSM outputs: storage strobe, pointer moves, commit and drop events
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wp[AW-1:0];
        wp_nxt   = wp;
        cwp_nxt  = cwp;
        commit   = 1'b0;
        drop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_en && wr_sop) begin
                    if (wr_full) begin
                        drop = wr_eop;
                    end else if (wr_eop && wr_err) begin
                        drop = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        wp_nxt = wp + ONE;
                        if (wr_eop) begin
                            cwp_nxt = wp + ONE;
                            commit  = 1'b1;
                        end
                    end
                end
            end
            S_IN_PKT: begin
                if (wr_en) begin
                    if (wr_sop) begin
                        // restart: the slot at cwp is always free while a packet is open
                        drop = 1'b1;
                        if (wr_eop && wr_err) begin
                            wp_nxt = cwp;
                        end else begin
                            mem_we   = 1'b1;
                            mem_addr = cwp[AW-1:0];
                            wp_nxt   = cwp + ONE;
                            if (wr_eop) begin
                                cwp_nxt = cwp + ONE;
                                commit  = 1'b1;
                            end
                        end
                    end else if (wr_full) begin
                        wp_nxt = cwp;
                        drop   = wr_eop;
                    end else if (wr_eop && wr_err) begin
                        wp_nxt = cwp;
                        drop   = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        wp_nxt = wp + ONE;
                        if (wr_eop) begin
                            cwp_nxt = wp + ONE;
                            commit  = 1'b1;
                        end
                    end
                end
            end
            S_DISCARD: begin
                drop = wr_en && wr_eop;
            end
            default: begin
                drop = 1'b0;
            end
        endcase
    end

    // beat storage, never reset
    always_ff @(posedge clk_156m25) begin
        if (mem_we) mem[mem_addr] <= {wr_sop, wr_eop, wr_mod, wr_data};
    end

    // write-side pointers
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            wp    <= '0;
            cwp   <= '0;
            cwp_q <= '0;
        end else begin
            wp    <= wp_nxt;
            cwp   <= cwp_nxt;
            cwp_q <= cwp;
        end
    end

    // show-ahead output register and read pointer
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            rp       <= '0;
            rd_valid <= 1'b0;
            rd_sop   <= 1'b0;
            rd_eop   <= 1'b0;
            rd_mod   <= '0;
            rd_data  <= '0;
        end else if (load) begin
            rp       <= rp + ONE;
            rd_valid <= 1'b1;
            {rd_sop, rd_eop, rd_mod, rd_data} <= head_word;
        end else if (rd_pop) begin
            rd_valid <= 1'b0;
        end
    end

    // committed packets held; commit and EOP pop in one cycle cancel
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            pkt_count <= '0;
        end else begin
            case ({commit, rd_pop && rd_eop})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

`ifdef PKT_SF_FIFO_DROP_STATS_EN
    // saturating dropped-packet counter
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n)                     drop_count <= 16'h0000;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pkt_sf_fifo.sv
// tb/tb_pkt_sf_fifo.sv - directed bench for pkt_sf_fifo
module tb_pkt_sf_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int MOD_W  = 3;
`ifdef PKT_SF_FIFO_DROP_STATS_EN
    localparam int DS = 1;
`else
    localparam int DS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0, wr_err = 1'b0;
    logic [MOD_W-1:0]  wr_mod = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_full;
    logic              rd_en = 1'b0;
    logic              rd_valid, rd_sop, rd_eop;
    logic [MOD_W-1:0]  rd_mod;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        pkt_count;
    logic [15:0]       drop_count;

    int vectors = 0;
    int miscompares = 0;

    pkt_sf_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_156m25(clk), .reset_156m25_n(rst_n),
        .wr_en(wr_en), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_mod(wr_mod),
        .wr_data(wr_data), .wr_err(wr_err), .wr_full(wr_full),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_mod(rd_mod), .rd_data(rd_data),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [MOD_W-1:0] m,
                        input logic [DATA_W-1:0] d, input logic err);
        wr_en = 1'b1; wr_sop = sop; wr_eop = eop; wr_mod = m; wr_data = d; wr_err = err;
        tick();
    endtask

    task automatic wr_idle();
        wr_en = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_err = 1'b0; wr_mod = '0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // three-beat packet, latency and ordering
        beat(1, 0, 0, 64'h1111_1111_1111_1111, 0);
        beat(0, 0, 0, 64'h2222_2222_2222_2222, 0);
        beat(0, 1, 5, 64'h3333_3333_3333_3333, 0);
        wr_idle();
        chk("p1_commit_pkt", pkt_count, 1);
        chk("p1_valid_n0", rd_valid, 0);
        tick();
        chk("p1_valid_n1", rd_valid, 0);
        tick();
        chk("p1_valid_n2", rd_valid, 1);
        chk("p1_b0_data", rd_data, 64'h1111_1111_1111_1111);
        chk("p1_b0_sop", rd_sop, 1);
        rd_en = 1'b1;
        tick();
        chk("p1_b1_data", rd_data, 64'h2222_2222_2222_2222);
        chk("p1_b1_eop", rd_eop, 0);
        tick();
        chk("p1_b2_data", rd_data, 64'h3333_3333_3333_3333);
        chk("p1_b2_eop", rd_eop, 1);
        chk("p1_b2_mod", rd_mod, 5);
        chk("p1_b2_pkt", pkt_count, 1);
        tick();
        rd_en = 1'b0;
        chk("p1_drained_valid", rd_valid, 0);
        chk("p1_drained_pkt", pkt_count, 0);

        // errored packet is dropped
        beat(1, 0, 0, 64'h44, 0);
        beat(0, 0, 0, 64'h45, 0);
        beat(0, 0, 0, 64'h46, 0);
        beat(0, 1, 2, 64'h47, 1);
        wr_idle();
        repeat (3) tick();
        chk("err_valid", rd_valid, 0);
        chk("err_pkt", pkt_count, 0);
        chk("err_drop", drop_count, 1 * DS);
        chk("err_wp", dut.wp, 3);
        chk("err_rp", dut.rp, 3);

        // oversized packet overflows and is discarded
        for (int i = 1; i <= 20; i++) begin
            beat(i == 1, i == 20, 0, 64'(i), 0);
            if (i == 16) chk("ovf_full_16", wr_full, 1);
            if (i == 17) chk("ovf_full_17", wr_full, 0);
        end
        wr_idle();
        repeat (3) tick();
        chk("ovf_valid", rd_valid, 0);
        chk("ovf_drop", drop_count, 2 * DS);
        chk("ovf_pkt", pkt_count, 0);
        beat(1, 0, 0, 64'hA1A1, 0);
        beat(0, 1, 0, 64'hA2A2, 0);
        wr_idle();
        tick();
        tick();
        chk("after_ovf_valid", rd_valid, 1);
        chk("after_ovf_b0", rd_data, 64'hA1A1);
        rd_en = 1'b1;
        tick();
        chk("after_ovf_b1", rd_data, 64'hA2A2);
        chk("after_ovf_eop", rd_eop, 1);
        chk("after_ovf_mod", rd_mod, 0);
        tick();
        rd_en = 1'b0;
        chk("after_ovf_empty", rd_valid, 0);

        // SOP without EOP restarts the packet
        beat(1, 0, 0, 64'hB1, 0);
        beat(0, 0, 0, 64'hB2, 0);
        beat(1, 0, 0, 64'hC1, 0);
        beat(0, 1, 7, 64'hC2, 0);
        wr_idle();
        chk("rst_pkt_drop", drop_count, 3 * DS);
        tick();
        tick();
        chk("rst_pkt_c1", rd_data, 64'hC1);
        chk("rst_pkt_c1_sop", rd_sop, 1);
        rd_en = 1'b1;
        tick();
        chk("rst_pkt_c2", rd_data, 64'hC2);
        chk("rst_pkt_c2_mod", rd_mod, 7);
        tick();
        rd_en = 1'b0;
        chk("rst_pkt_empty", rd_valid, 0);
        chk("rst_pkt_count", pkt_count, 0);

        // commit B while popping EOP of A
        beat(1, 1, 1, 64'hD1, 0);
        wr_idle();
        tick();
        tick();
        chk("ab_a_valid", rd_valid, 1);
        chk("ab_a_data", rd_data, 64'hD1);
        rd_en = 1'b1;
        beat(1, 1, 2, 64'hE1, 0);
        wr_idle();
        rd_en = 1'b0;
        chk("ab_pkt_same", pkt_count, 1);
        chk("ab_valid_0", rd_valid, 0);
        tick();
        tick();
        chk("ab_b_valid", rd_valid, 1);
        chk("ab_b_data", rd_data, 64'hE1);

        // asynchronous reset while a beat is presented
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_pkt", pkt_count, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_drop", drop_count, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", rd_valid, 0);
        chk("post_rst_full", wr_full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
